// File: rtl/mem_access_if.sv
// mem_access_if: EX-side record, data-RAM handshake and write-back record of the memory stage.
interface mem_access_if;
    logic        in_valid;
    logic [31:0] result_in;
    logic        write_reg_en_in;
    logic [4:0]  write_reg_addr_in;
    logic [2:0]  mem_op;
    logic [31:0] mem_wdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;
    logic        stall_req;
    logic        wb_valid;
    logic [31:0] result_out;
    logic        write_reg_en_out;
    logic [4:0]  write_reg_addr_out;
    logic        addr_err;
    modport master (
        input  in_valid, result_in, write_reg_en_in, write_reg_addr_in, mem_op, mem_wdata,
        input  ram_rdata, ram_ready,
        output ram_en, ram_we, ram_addr, ram_wdata, stall_req,
        output wb_valid, result_out, write_reg_en_out, write_reg_addr_out, addr_err
    );
    modport slave (
        output in_valid, result_in, write_reg_en_in, write_reg_addr_in, mem_op, mem_wdata,
        output ram_rdata, ram_ready,
        input  ram_en, ram_we, ram_addr, ram_wdata, stall_req,
        input  wb_valid, result_out, write_reg_en_out, write_reg_addr_out, addr_err
    );
endinterface

// File: rtl/mem_access.sv
// mem_access: memory stage; RAM request/ready handshake, load extension and registered MEM/WB record.
module mem_access (
    input logic clk,
    input logic rst,
    mem_access_if.master bus
);
    localparam logic [2:0] OP_LB = 3'b001, OP_LBU = 3'b010, OP_LH = 3'b011, OP_LHU = 3'b100,
                           OP_LW = 3'b101, OP_SB = 3'b110, OP_SW = 3'b111;
    typedef enum logic {IDLE, WAIT} state_t;
    state_t st, st_nx;
    logic [2:0]  op_q, op;
    logic [31:0] addr_q, wdata_q, addr, wdata, load_v;
    logic        en_q, en, in_wait, is_mem, is_store, is_load, aligned, accept, misalign, req, done;
    logic [4:0]  dest_q, dest;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    // In WAIT the bus and completion come from the latched copy so upstream may change freely.
    always_comb begin
        in_wait = st == WAIT;
        op = in_wait ? op_q : bus.mem_op;
        addr = in_wait ? addr_q : bus.result_in;
        wdata = in_wait ? wdata_q : bus.mem_wdata;
        en = in_wait ? en_q : bus.write_reg_en_in;
        dest = in_wait ? dest_q : bus.write_reg_addr_in;
        is_mem = op != 3'b000;
        is_store = op[2] & op[1];
        is_load = is_mem & ~is_store;
        aligned = (op == OP_LH || op == OP_LHU) ? ~addr[0] :
                  (op == OP_LW || op == OP_SW) ? addr[1:0] == 2'b00 : 1'b1;
        accept = ~in_wait & bus.in_valid & is_mem & aligned;
        misalign = ~in_wait & bus.in_valid & is_mem & ~aligned;
        req = ~rst & (accept | in_wait);
        done = req & bus.ram_ready;
        bus.ram_en = req;
        bus.ram_addr = req ? {addr[31:2], 2'b00} : 32'h0;
        bus.ram_we = ~(req & is_store) ? 4'b0000 : op == OP_SB ? 4'b0001 << addr[1:0] : 4'b1111;
        bus.ram_wdata = ~(req & is_store) ? 32'h0 : op == OP_SB ? {4{wdata[7:0]}} : wdata;
        bus.stall_req = req & ~bus.ram_ready;
        byte_v = 8'(bus.ram_rdata >> {addr[1:0], 3'b000});
        half_v = addr[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
        load_v = op == OP_LB  ? {{24{byte_v[7]}}, byte_v} :
                 op == OP_LBU ? {24'h0, byte_v} :
                 op == OP_LH  ? {{16{half_v[15]}}, half_v} :
                 op == OP_LHU ? {16'h0, half_v} : bus.ram_rdata;
        st_nx = (accept & ~bus.ram_ready) ? WAIT : (in_wait & bus.ram_ready) ? IDLE : st;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            op_q <= 3'b000;
            addr_q <= 32'h0;
            wdata_q <= 32'h0;
            en_q <= 1'b0;
            dest_q <= 5'd0;
            bus.wb_valid <= 1'b0;
            bus.result_out <= 32'h0;
            bus.write_reg_en_out <= 1'b0;
            bus.write_reg_addr_out <= 5'd0;
            bus.addr_err <= 1'b0;
        end else begin
            st <= st_nx;
            bus.addr_err <= misalign;
            if (accept) begin
                op_q <= op;
                addr_q <= addr;
                wdata_q <= wdata;
                en_q <= en;
                dest_q <= dest;
            end
            if (done) begin
                bus.wb_valid <= 1'b1;
                bus.result_out <= is_load ? load_v : addr;
                bus.write_reg_en_out <= is_load & en;
                bus.write_reg_addr_out <= dest;
            end else if (~in_wait & bus.in_valid & ~is_mem) begin
                bus.wb_valid <= 1'b1;
                bus.result_out <= bus.result_in;
                bus.write_reg_en_out <= bus.write_reg_en_in;
                bus.write_reg_addr_out <= bus.write_reg_addr_in;
            end else begin
                bus.wb_valid <= 1'b0;
                bus.write_reg_en_out <= 1'b0;
            end
        end
    end
endmodule
